// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-select width, hazard FSM states, forwarding
// select encodings and the md countdown width.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  // Hazard controller state; records which condition owned the last cycle.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    LU_STALL = 2'd2,
    MD_STALL = 2'd3
  } hz_state_t;

  // ALU operand source select.
  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b01;
  localparam fwd_sel_t FWD_MEMWB = 2'b10;

  // Wide enough for the largest legal md latency (15).
  localparam int MD_CNT_W = 4;

  // The younger producer (EX/MEM) wins over the older one (MEM/WB).
  function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_EXMEM;
    else if (wb_hit) return FWD_MEMWB;
    else             return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of the pipeline-facing signals of the hazard controller.
// No handshake: every signal is level-sampled each cycle; there is no
// valid/ready pair and nothing is held back waiting for acceptance.
interface hazard_ctrl_if #(
  parameter int REG_W = $bits(cpu_types_pkg::regbits_t),
  parameter int CNT_W = 16
);
  logic             ihit, dhit, mem_req;
  logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt;
  logic             ex_memread, ex_regwr;
  logic [REG_W-1:0] ex_wsel;
  logic             mem_regwr, wb_regwr;
  logic [REG_W-1:0] mem_wsel, wb_wsel;
  logic             id_md_use, md_start, jump, branch_taken;
  logic             pcWEN, ifid_en, ifid_flush, idex_en, idex_flush;
  logic             exmem_en, exmem_flush, memwb_en;
  logic [1:0]       fwd_a, fwd_b;
  logic             md_busy;
  logic [CNT_W-1:0] lu_stall_cnt, md_stall_cnt, memwait_cnt;

  // Pipeline side: supplies stage information, consumes latch controls.
  modport master (
    output ihit, dhit, mem_req, id_rs, id_rt, ex_rs, ex_rt,
           ex_memread, ex_regwr, ex_wsel, mem_regwr, wb_regwr,
           mem_wsel, wb_wsel, id_md_use, md_start, jump, branch_taken,
    input  pcWEN, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, fwd_a, fwd_b, md_busy,
           lu_stall_cnt, md_stall_cnt, memwait_cnt
  );

  // Hazard controller side.
  modport slave (
    input  ihit, dhit, mem_req, id_rs, id_rt, ex_rs, ex_rt,
           ex_memread, ex_regwr, ex_wsel, mem_regwr, wb_regwr,
           mem_wsel, wb_wsel, id_md_use, md_start, jump, branch_taken,
    output pcWEN, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, fwd_a, fwd_b, md_busy,
           lu_stall_cnt, md_stall_cnt, memwait_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  // Count up on i_inc, stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (i_clr)                  r_cnt <= '0;
    else if (i_inc && (r_cnt != '1)) r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, stall/flush arbitration,
// multiply/divide busy tracking and stall performance counters.
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REG_W  = $bits(regbits_t),
  parameter int MD_LAT = 4,   // legal 2..15
  parameter int CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_req,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_memread,
  input  logic             ex_regwr,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic             mem_regwr,
  input  logic             wb_regwr,
  input  logic [REG_W-1:0] mem_wsel,
  input  logic [REG_W-1:0] wb_wsel,
  input  logic             id_md_use,
  input  logic             md_start,
  input  logic             jump,
  input  logic             branch_taken,
  output logic             pcWEN,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             md_busy,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] md_stall_cnt,
  output logic [CNT_W-1:0] memwait_cnt,
  output hz_state_t        o_dbg_state
);
  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT - 1);

  hz_state_t           r_state;
  hz_state_t           w_state_nxt;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic                w_mem_wait, w_lu_haz, w_md_haz;
  logic                w_inc_mw, w_inc_lu, w_inc_md;

  // Forwarding ignores writes to register 0.
  assign fwd_a = fwd_pick(mem_regwr && (mem_wsel != '0) && (mem_wsel == ex_rs),
                          wb_regwr  && (wb_wsel  != '0) && (wb_wsel  == ex_rs));
  assign fwd_b = fwd_pick(mem_regwr && (mem_wsel != '0) && (mem_wsel == ex_rt),
                          wb_regwr  && (wb_wsel  != '0) && (wb_wsel  == ex_rt));

  assign w_mem_wait = mem_req && !dhit;
  assign w_lu_haz   = ex_memread && ex_regwr && (ex_wsel != '0) &&
                      ((ex_wsel == id_rs) || (ex_wsel == id_rt));
  assign w_md_haz   = id_md_use && md_busy;
  assign md_busy    = (r_md_cnt != '0);

  // A cycle is charged to exactly one counter: the condition that won arbitration.
  assign w_inc_mw = w_mem_wait;
  assign w_inc_lu = !w_mem_wait && !branch_taken && w_lu_haz;
  assign w_inc_md = !w_mem_wait && !branch_taken && !w_lu_haz && w_md_haz;

  // Priority arbitration of latch controls and next state.
  always_comb begin
    pcWEN       = ihit;
    ifid_en     = 1'b1;
    ifid_flush  = !ihit;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    w_state_nxt = RUN;
    if (w_mem_wait) begin
      pcWEN       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      w_state_nxt = MEM_WAIT;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_lu_haz || w_md_haz) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX, let older stages drain.
      pcWEN       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b1;
      w_state_nxt = w_lu_haz ? LU_STALL : MD_STALL;
    end else if (jump) begin
      ifid_flush = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  // md countdown; a new start restarts it, a start during mem_wait is dropped.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                          r_md_cnt <= '0;
    else if (md_start && !w_mem_wait)   r_md_cnt <= MD_LOAD;
    else if (r_md_cnt != '0)            r_md_cnt <= r_md_cnt - MD_CNT_W'(1);
  end

  assign o_dbg_state = r_state;

  sat_counter #(.W(CNT_W)) u_cnt_lu (
    .clk(CLK), .rst_n(nRST), .i_clr(1'b0), .i_inc(w_inc_lu), .o_cnt(lu_stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_cnt_md (
    .clk(CLK), .rst_n(nRST), .i_clr(1'b0), .i_inc(w_inc_md), .o_cnt(md_stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_cnt_mw (
    .clk(CLK), .rst_n(nRST), .i_clr(1'b0), .i_inc(w_inc_mw), .o_cnt(memwait_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: vector table, random forwarding, and
// hand-written multi-cycle sequences.
module tb_hazard_ctrl;
  import cpu_types_pkg::*;

  localparam int CNT_W = 16;
  // Control bundle order: pcWEN ifid_en ifid_flush idex_en idex_flush exmem_en exmem_flush memwb_en
  localparam logic [7:0] CTL_RUN      = 8'b1101_0101;
  localparam logic [7:0] CTL_RUN_MISS = 8'b0111_0101;
  localparam logic [7:0] CTL_FREEZE   = 8'b0000_0000;
  localparam logic [7:0] CTL_BR       = 8'b1111_1101;
  localparam logic [7:0] CTL_BR_MISS  = 8'b0111_1101;
  localparam logic [7:0] CTL_STALL    = 8'b0001_1101;
  localparam logic [7:0] CTL_JMP      = 8'b1111_0101;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  hazard_ctrl_if #(.REG_W(5), .CNT_W(CNT_W)) bus ();
  hz_state_t  dbg_state, s_dbg_state;
  logic       s_pcWEN, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush;
  logic       s_exmem_en, s_exmem_flush, s_memwb_en, s_md_busy;
  logic [1:0] s_fwd_a, s_fwd_b;
  logic [1:0] s_lu_cnt, s_md_cnt, s_mw_cnt;
  logic [7:0] act_ctl;

  hazard_ctrl #(.REG_W(5), .MD_LAT(4), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(bus.ihit), .dhit(bus.dhit), .mem_req(bus.mem_req),
    .id_rs(bus.id_rs), .id_rt(bus.id_rt), .ex_rs(bus.ex_rs), .ex_rt(bus.ex_rt),
    .ex_memread(bus.ex_memread), .ex_regwr(bus.ex_regwr), .ex_wsel(bus.ex_wsel),
    .mem_regwr(bus.mem_regwr), .wb_regwr(bus.wb_regwr), .mem_wsel(bus.mem_wsel),
    .wb_wsel(bus.wb_wsel), .id_md_use(bus.id_md_use), .md_start(bus.md_start),
    .jump(bus.jump), .branch_taken(bus.branch_taken),
    .pcWEN(bus.pcWEN), .ifid_en(bus.ifid_en), .ifid_flush(bus.ifid_flush),
    .idex_en(bus.idex_en), .idex_flush(bus.idex_flush), .exmem_en(bus.exmem_en),
    .exmem_flush(bus.exmem_flush), .memwb_en(bus.memwb_en),
    .fwd_a(bus.fwd_a), .fwd_b(bus.fwd_b), .md_busy(bus.md_busy),
    .lu_stall_cnt(bus.lu_stall_cnt), .md_stall_cnt(bus.md_stall_cnt),
    .memwait_cnt(bus.memwait_cnt), .o_dbg_state(dbg_state)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  hazard_ctrl #(.REG_W(5), .MD_LAT(4), .CNT_W(2)) dut_sat (
    .CLK(CLK), .nRST(nRST), .ihit(bus.ihit), .dhit(bus.dhit), .mem_req(bus.mem_req),
    .id_rs(bus.id_rs), .id_rt(bus.id_rt), .ex_rs(bus.ex_rs), .ex_rt(bus.ex_rt),
    .ex_memread(bus.ex_memread), .ex_regwr(bus.ex_regwr), .ex_wsel(bus.ex_wsel),
    .mem_regwr(bus.mem_regwr), .wb_regwr(bus.wb_regwr), .mem_wsel(bus.mem_wsel),
    .wb_wsel(bus.wb_wsel), .id_md_use(bus.id_md_use), .md_start(bus.md_start),
    .jump(bus.jump), .branch_taken(bus.branch_taken),
    .pcWEN(s_pcWEN), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
    .idex_en(s_idex_en), .idex_flush(s_idex_flush), .exmem_en(s_exmem_en),
    .exmem_flush(s_exmem_flush), .memwb_en(s_memwb_en),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .md_busy(s_md_busy),
    .lu_stall_cnt(s_lu_cnt), .md_stall_cnt(s_md_cnt),
    .memwait_cnt(s_mw_cnt), .o_dbg_state(s_dbg_state)
  );

  assign act_ctl = {bus.pcWEN, bus.ifid_en, bus.ifid_flush, bus.idex_en,
                    bus.idex_flush, bus.exmem_en, bus.exmem_flush, bus.memwb_en};

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic       ihit, dhit, mem_req, branch, jump, ex_memread, ex_regwr;
    logic [4:0] ex_wsel, id_rs, id_rt, ex_rs, ex_rt;
    logic       mem_regwr, wb_regwr;
    logic [4:0] mem_wsel, wb_wsel;
    logic [7:0] exp_ctl;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  vec_t vecs[$];
  logic [11:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t base(input string n);
    vec_t v;
    v.name = n; v.ihit = 1'b1; v.dhit = 1'b1; v.mem_req = 1'b0; v.branch = 1'b0;
    v.jump = 1'b0; v.ex_memread = 1'b0; v.ex_regwr = 1'b0; v.ex_wsel = '0;
    v.id_rs = '0; v.id_rt = '0; v.ex_rs = '0; v.ex_rt = '0;
    v.mem_regwr = 1'b0; v.wb_regwr = 1'b0; v.mem_wsel = '0; v.wb_wsel = '0;
    v.exp_ctl = CTL_RUN; v.exp_fa = 2'b00; v.exp_fb = 2'b00;
    return v;
  endfunction

  function automatic logic [1:0] fwd_model(input logic mw, input logic [4:0] ms,
                                           input logic ww, input logic [4:0] ws,
                                           input logic [4:0] src);
    if (mw && ms != 5'd0 && ms == src) return 2'b01;
    if (ww && ws != 5'd0 && ws == src) return 2'b10;
    return 2'b00;
  endfunction

  // ---------------- scoreboard / checks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.ihit = 1'b1; bus.dhit = 1'b1; bus.mem_req = 1'b0; bus.branch_taken = 1'b0;
    bus.jump = 1'b0; bus.ex_memread = 1'b0; bus.ex_regwr = 1'b0; bus.ex_wsel = '0;
    bus.id_rs = '0; bus.id_rt = '0; bus.ex_rs = '0; bus.ex_rt = '0;
    bus.mem_regwr = 1'b0; bus.wb_regwr = 1'b0; bus.mem_wsel = '0; bus.wb_wsel = '0;
    bus.id_md_use = 1'b0; bus.md_start = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_vec(input vec_t v);
    bus.ihit = v.ihit; bus.dhit = v.dhit; bus.mem_req = v.mem_req;
    bus.branch_taken = v.branch; bus.jump = v.jump; bus.ex_memread = v.ex_memread;
    bus.ex_regwr = v.ex_regwr; bus.ex_wsel = v.ex_wsel; bus.id_rs = v.id_rs;
    bus.id_rt = v.id_rt; bus.ex_rs = v.ex_rs; bus.ex_rt = v.ex_rt;
    bus.mem_regwr = v.mem_regwr; bus.wb_regwr = v.wb_regwr;
    bus.mem_wsel = v.mem_wsel; bus.wb_wsel = v.wb_wsel;
    exp_q.push_back({v.exp_ctl, v.exp_fa, v.exp_fb});
  endtask

  task automatic sample_vec(input string n);
    logic [11:0] e;
    @(negedge CLK);
    if (exp_q.size() == 0) begin
      chk({n, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({n, "_ctl"}, 32'(act_ctl), 32'(e[11:4]));
      chk({n, "_fwd_a"}, 32'(bus.fwd_a), 32'(e[3:2]));
      chk({n, "_fwd_b"}, 32'(bus.fwd_b), 32'(e[1:0]));
    end
  endtask

  // ---------------- main test ----------------
  initial begin
    vec_t v;
    int busy_cycles, stall_cycles;

    v = base("run_hit");        vecs.push_back(v);
    v = base("run_miss");       v.ihit = 0; v.exp_ctl = CTL_RUN_MISS; vecs.push_back(v);
    v = base("memwait");        v.mem_req = 1; v.dhit = 0; v.exp_ctl = CTL_FREEZE; vecs.push_back(v);
    v = base("memreq_hit");     v.mem_req = 1; vecs.push_back(v);
    v = base("dmiss_noreq");    v.dhit = 0; vecs.push_back(v);
    v = base("branch");         v.branch = 1; v.exp_ctl = CTL_BR; vecs.push_back(v);
    v = base("branch_miss");    v.branch = 1; v.ihit = 0; v.exp_ctl = CTL_BR_MISS; vecs.push_back(v);
    v = base("memwait_branch"); v.mem_req = 1; v.dhit = 0; v.branch = 1; v.exp_ctl = CTL_FREEZE; vecs.push_back(v);
    v = base("lu_rt");          v.ex_memread = 1; v.ex_regwr = 1; v.ex_wsel = 9; v.id_rt = 9; v.exp_ctl = CTL_STALL; vecs.push_back(v);
    v = base("lu_rs");          v.ex_memread = 1; v.ex_regwr = 1; v.ex_wsel = 7; v.id_rs = 7; v.exp_ctl = CTL_STALL; vecs.push_back(v);
    v = base("lu_r0");          v.ex_memread = 1; v.ex_regwr = 1; vecs.push_back(v);
    v = base("lu_nowr");        v.ex_memread = 1; v.ex_wsel = 9; v.id_rt = 9; vecs.push_back(v);
    v = base("lu_noread");      v.ex_regwr = 1; v.ex_wsel = 9; v.id_rt = 9; vecs.push_back(v);
    v = base("lu_branch");      v.ex_memread = 1; v.ex_regwr = 1; v.ex_wsel = 9; v.id_rt = 9; v.branch = 1; v.exp_ctl = CTL_BR; vecs.push_back(v);
    v = base("lu_jump");        v.ex_memread = 1; v.ex_regwr = 1; v.ex_wsel = 9; v.id_rt = 9; v.jump = 1; v.exp_ctl = CTL_STALL; vecs.push_back(v);
    v = base("lu_memwait");     v.ex_memread = 1; v.ex_regwr = 1; v.ex_wsel = 9; v.id_rt = 9; v.mem_req = 1; v.dhit = 0; v.exp_ctl = CTL_FREEZE; vecs.push_back(v);
    v = base("jump");           v.jump = 1; v.exp_ctl = CTL_JMP; vecs.push_back(v);
    v = base("jump_miss");      v.jump = 1; v.ihit = 0; v.exp_ctl = CTL_RUN_MISS; vecs.push_back(v);
    v = base("fwd_mem");        v.mem_regwr = 1; v.mem_wsel = 8; v.ex_rs = 8; v.wb_regwr = 1; v.wb_wsel = 8; v.exp_fa = 2'b01; vecs.push_back(v);
    v = base("fwd_wb");         v.mem_regwr = 1; v.mem_wsel = 0; v.ex_rs = 8; v.wb_regwr = 1; v.wb_wsel = 8; v.exp_fa = 2'b10; vecs.push_back(v);
    v = base("fwd_b_mem");      v.mem_regwr = 1; v.mem_wsel = 3; v.ex_rt = 3; v.ex_rs = 5; v.wb_regwr = 1; v.wb_wsel = 5; v.exp_fa = 2'b10; v.exp_fb = 2'b01; vecs.push_back(v);
    v = base("fwd_off");        v.mem_wsel = 3; v.ex_rs = 3; v.wb_wsel = 3; vecs.push_back(v);
    v = base("fwd_wb_r0");      v.wb_regwr = 1; v.mem_regwr = 1; vecs.push_back(v);

    // Reset state, checked while reset is held.
    nRST = 1'b0;
    idle();
    #2;
    chk("rst_md_busy", 32'(bus.md_busy), 32'd0);
    chk("rst_lu_cnt", 32'(bus.lu_stall_cnt), 32'd0);
    chk("rst_md_cnt", 32'(bus.md_stall_cnt), 32'd0);
    chk("rst_mw_cnt", 32'(bus.memwait_cnt), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(RUN));
    chk("rst_ctl", 32'(act_ctl), 32'(CTL_RUN));
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // Table vectors.
    foreach (vecs[i]) begin
      drive_vec(vecs[i]);
      sample_vec(vecs[i].name);
      tick();
    end

    // Random forwarding patterns with a small register range to force collisions.
    for (int i = 0; i < 20; i++) begin
      v = base("rnd_fwd");
      v.mem_regwr = 1'($urandom_range(0, 1)); v.wb_regwr = 1'($urandom_range(0, 1));
      v.mem_wsel = 5'($urandom_range(0, 3));  v.wb_wsel = 5'($urandom_range(0, 3));
      v.ex_rs = 5'($urandom_range(0, 3));     v.ex_rt = 5'($urandom_range(0, 3));
      v.exp_fa = fwd_model(v.mem_regwr, v.mem_wsel, v.wb_regwr, v.wb_wsel, v.ex_rs);
      v.exp_fb = fwd_model(v.mem_regwr, v.mem_wsel, v.wb_regwr, v.wb_wsel, v.ex_rt);
      drive_vec(v);
      sample_vec(v.name);
      tick();
    end
    idle();

    // Mid-run reset clears the counters the table has built up.
    nRST = 1'b0;
    #1;
    chk("rst2_lu_cnt", 32'(bus.lu_stall_cnt), 32'd0);
    chk("rst2_mw_cnt", 32'(bus.memwait_cnt), 32'd0);
    chk("rst2_state", 32'(dbg_state), 32'(RUN));
    #1 nRST = 1'b1;
    tick();

    // Load-use hazard: one stall cycle, one count.
    bus.ex_memread = 1; bus.ex_regwr = 1; bus.ex_wsel = 9; bus.id_rt = 9;
    @(negedge CLK);
    chk("lu_seq_ctl", 32'(act_ctl), 32'(CTL_STALL));
    chk("lu_seq_cnt0", 32'(bus.lu_stall_cnt), 32'd0);
    tick();
    idle();
    @(negedge CLK);
    chk("lu_seq_cnt1", 32'(bus.lu_stall_cnt), 32'd1);
    chk("lu_seq_state", 32'(dbg_state), 32'(LU_STALL));
    chk("lu_seq_release", 32'(act_ctl), 32'(CTL_RUN));
    tick();

    // md start pulse with a dependent instruction held in ID.
    bus.md_start = 1; bus.id_md_use = 1;
    @(negedge CLK);
    chk("md_start_busy", 32'(bus.md_busy), 32'd0);
    chk("md_start_ctl", 32'(act_ctl), 32'(CTL_RUN));
    tick();
    bus.md_start = 0;
    busy_cycles = 0; stall_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (bus.md_busy) busy_cycles++;
      if (act_ctl == CTL_STALL) stall_cycles++;
      if (i == 1) chk("md_state", 32'(dbg_state), 32'(MD_STALL));
      tick();
    end
    chk("md_busy_cycles", 32'(busy_cycles), 32'd3);
    chk("md_stall_cycles", 32'(stall_cycles), 32'd3);
    chk("md_stall_cnt", 32'(bus.md_stall_cnt), 32'd3);
    chk("md_lu_cnt_same", 32'(bus.lu_stall_cnt), 32'd1);
    idle();

    // md_start during a data-cache miss is dropped.
    bus.mem_req = 1; bus.dhit = 0; bus.md_start = 1;
    tick();
    idle();
    @(negedge CLK);
    chk("md_start_in_memwait", 32'(bus.md_busy), 32'd0);
    tick();

    // Restart while busy reloads the full latency.
    bus.md_start = 1;
    tick();
    tick();
    bus.md_start = 0;
    busy_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (bus.md_busy) busy_cycles++;
      tick();
    end
    chk("md_reload_busy", 32'(busy_cycles), 32'd3);

    // Data miss beats a taken branch; branch flush appears once the miss clears.
    bus.mem_req = 1; bus.dhit = 0; bus.branch_taken = 1;
    @(negedge CLK);
    chk("miss_br_ctl", 32'(act_ctl), 32'(CTL_FREEZE));
    tick();
    bus.dhit = 1;
    @(negedge CLK);
    chk("miss_br_after", 32'(act_ctl), 32'(CTL_BR));
    chk("miss_br_state", 32'(dbg_state), 32'(MEM_WAIT));
    tick();
    idle();
    @(negedge CLK);
    chk("br_state_run", 32'(dbg_state), 32'(RUN));
    tick();

    // Saturation of a 2-bit counter over five miss cycles.
    nRST = 1'b0;
    #1 nRST = 1'b1;
    tick();
    bus.mem_req = 1; bus.dhit = 0;
    repeat (2) tick();
    chk("sat_mw_2", 32'(s_mw_cnt), 32'd2);
    repeat (3) tick();
    idle();
    chk("sat_mw_3", 32'(s_mw_cnt), 32'd3);
    chk("wide_mw_5", 32'(bus.memwait_cnt), 32'd5);

    // Reset in the middle of an md countdown.
    bus.md_start = 1;
    tick();
    bus.md_start = 0;
    #2;
    chk("mdrst_busy_before", 32'(bus.md_busy), 32'd1);
    nRST = 1'b0;
    #1;
    chk("mdrst_busy", 32'(bus.md_busy), 32'd0);
    chk("mdrst_mw_cnt", 32'(bus.memwait_cnt), 32'd0);
    chk("mdrst_sat_mw_cnt", 32'(s_mw_cnt), 32'd0);
    chk("mdrst_md_cnt", 32'(bus.md_stall_cnt), 32'd0);
    chk("mdrst_lu_cnt", 32'(bus.lu_stall_cnt), 32'd0);
    #2 nRST = 1'b1;
    tick();
    chk("mdrst_post_busy", 32'(bus.md_busy), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): REG_W, 5, register-select width.
REQ-002 Parameter MD_LAT, 4, multiply/divide unit latency in cycles; legal range 2..15.
REQ-003 Parameter CNT_W, 16, width of the stall performance counters.
REQ-004 Ports SHALL be (name, direction, width, meaning): CLK, in, 1, sole clock, rising edge.
REQ-005 nRST, in, 1, reset; asynchronous, active-low.
REQ-006 ihit, dhit, in, 1 each, instruction / data cache hit.
REQ-007 mem_req, in, 1, MEM stage holds a load or store.
REQ-008 id_rs, id_rt, ex_rs, ex_rt, in, REG_W each, source selects in ID and EX.
REQ-009 ex_memread, ex_regwr, in, 1 each, EX stage load and write-enable flags; ex_wsel, in, REG_W, EX destination.
REQ-010 mem_regwr, wb_regwr, in, 1 each, and mem_wsel, wb_wsel, in, REG_W each: MEM/WB write-back information.
REQ-011 id_md_use, in, 1, ID holds mult/div/mfhi/mflo; md_start, in, 1, EX issues mult/div this cycle.
REQ-012 jump, in, 1, jump in ID; branch_taken, in, 1, taken branch resolved in EX.
REQ-013 pcWEN, out, 1; ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, out, 1 each: latch controls.
REQ-014 fwd_a, fwd_b, out, 2 each, ALU operand select: 00 register file, 01 EX/MEM, 10 MEM/WB.
REQ-015 md_busy, out, 1; lu_stall_cnt, md_stall_cnt, memwait_cnt, out, CNT_W each.

Function
REQ-016 fwd_a SHALL be 01 if mem_regwr, mem_wsel!=0 and mem_wsel==ex_rs; else 10 if wb_regwr, wb_wsel!=0 and wb_wsel==ex_rs; else 00. fwd_b SHALL use the same rule with ex_rt; both purely combinational.
REQ-017 Conditions: mem_wait = mem_req & ~dhit; lu_haz = ex_memread & ex_regwr & ex_wsel!=0 & (ex_wsel==id_rs | ex_wsel==id_rt); md_haz = id_md_use & md_busy.
REQ-018 Priority 1, mem_wait: pcWEN, ifid_en, idex_en, exmem_en and memwb_en SHALL be 0, all flushes 0.
REQ-019 Priority 2, branch_taken: ifid_flush=1, idex_flush=1, pcWEN=ihit, all enables 1.
REQ-020 Priority 3, lu_haz or md_haz: pcWEN=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
REQ-021 Priority 4, jump: ifid_flush=1, pcWEN=ihit.
REQ-022 Otherwise pcWEN=ihit, all enables 1; ifid_flush=~ihit.
REQ-023 exmem_flush SHALL always be 0.
REQ-024 State register SHALL hold states RUN, MEM_WAIT, LU_STALL, MD_STALL, set each cycle to the highest active condition: mem_wait, then lu_haz, then md_haz, else RUN; branch_taken SHALL force RUN.
REQ-025 md counter: md_start SHALL load MD_LAT-1 (loading again if already busy); the counter SHALL decrement to 0 and hold; md_busy = counter!=0.
REQ-026 md_start SHALL be ignored during mem_wait.
REQ-027 Each counter SHALL add 1 per cycle the matching condition drives the outcome (memwait_cnt for REQ-018, lu_stall_cnt when lu_haz selects REQ-020, otherwise md_stall_cnt for REQ-020) and saturate at all-ones.
REQ-028 lu_haz and md_haz together SHALL count only in lu_stall_cnt.

Reset
REQ-029 nRST low SHALL asynchronously clear state to RUN, the md counter to 0 (md_busy=0) and all three perf counters to 0.
REQ-030 nRST low mid multiply SHALL abandon the operation; md_busy SHALL read 0 on the first post-reset cycle.

Structure
REQ-031 The state enum and forwarding-select encodings SHALL live in cpu_types_pkg; the REG_W default SHALL equal that package's regbits_t width.
REQ-032 One sub-module, sat_counter (width-parameterised, increment/clear), SHALL be instantiated three times.

Verification
REQ-033 mem_regwr=1, mem_wsel=8, ex_rs=8, wb_regwr=1, wb_wsel=8 -> fwd_a=01; with mem_wsel=0 instead -> fwd_a=10.
REQ-034 ex_memread=1, ex_regwr=1, ex_wsel=9, id_rt=9, ihit=1 -> pcWEN=0, ifid_en=0, idex_flush=1 for one cycle; lu_stall_cnt increments by 1.
REQ-035 md_start pulse, MD_LAT=4, id_md_use held -> md_busy high 3 cycles, 3 stall cycles, md_stall_cnt=3.
REQ-036 mem_req=1, dhit=0 together with branch_taken=1 -> all enables 0 and no flush; dhit=1 next cycle -> ifid_flush=idex_flush=1.
REQ-037 CNT_W=2 with 5 consecutive mem_wait cycles -> memwait_cnt saturates at 3.
REQ-038 nRST asserted during md countdown -> md_busy=0 and all counters 0 before the next CLK edge.
